conv_window_ctrl: RTL and testbench
===================================

# conv_window_ctrl

Sequencer for the sliding-window shift FIFO of a convolution layer. It walks every filter/channel pair of the layer and issues IFM RAM reads, one pixel per cycle. It pushes returned pixels into the window FIFO (`fifo_enable`) and tracks row/column position. It then flags each cycle in which the FIFO taps hold a complete, non-wrapping K×K window, together with the matching OFM and weight-memory addresses. It sits between the IFM RAM, the window FIFO and the MAC/accumulator stage.

## Interface
Parameters:
- `IFM_SIZE`, 32: IFM width = height.
- `IFM_DEPTH`, 3: input channels.
- `KERNAL_SIZE`, 6: kernel edge K.
- `NUMBER_OF_FILTERS`, 6: output channels.
- `IFM_SIZE_NEXT`, `IFM_SIZE-KERNAL_SIZE+1`: OFM edge.
- `ADDRESS_SIZE_IFM`, `$clog2(IFM_SIZE*IFM_SIZE*IFM_DEPTH)`.
- `ADDRESS_SIZE_NEXT_IFM`, `$clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT)`.
- `ADDRESS_SIZE_WM`, `$clog2(IFM_DEPTH*NUMBER_OF_FILTERS)`.

Ports:
- `clk` in 1: the block's only clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: pulse; sampled only in IDLE.
- `ifm_rd_en` out 1: IFM RAM read strobe. The RAM holds its output while this is low.
- `ifm_rd_addr` out ADDRESS_SIZE_IFM: `depth*IFM_SIZE² + row*IFM_SIZE + col`.
- `fifo_enable` out 1: window FIFO shift strobe.
- `window_valid` out 1: FIFO taps hold a valid window.
- `window_ready` in 1: MAC stage accepts the window.
- `ofm_wr_addr` out ADDRESS_SIZE_NEXT_IFM: OFM address of the current window.
- `wm_addr` out ADDRESS_SIZE_WM: `filter*IFM_DEPTH + depth`.
- `first_depth` out 1: current window belongs to depth 0 (accumulator clear).
- `last_depth` out 1: current window belongs to depth IFM_DEPTH-1 (OFM write-back).
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse after the last window of the last filter is accepted.

## Operation
- States: IDLE, LOAD, DRAIN, NEXT, DONE.
- IDLE: on `start`, clear counters `filter`, `depth`, `rd_pix` and `push_pix`, then go to LOAD.
- `advance` = `!(window_valid && !window_ready)`.
- LOAD:
  - `ifm_rd_en` = `advance && rd_pix < IFM_SIZE²`; `rd_pix` increments on each read.
  - `rd_pending` is set on a read and cleared on a push.
  - `fifo_enable` = `rd_pending && advance`; `push_pix` increments on each push.
  - When the push of pixel `IFM_SIZE²-1` occurs, go to DRAIN.
- Window detection on each push of pixel (r, c), where r = push_pix / IFM_SIZE and c = push_pix % IFM_SIZE:
  - If r ≥ K-1 and c ≥ K-1: next cycle `window_valid`=1 and `ofm_wr_addr` = `(r-K+1)*IFM_SIZE_NEXT + (c-K+1)`.
  - Otherwise `window_valid` clears on `window_ready`.
  - Use row/column counters, not division.
- DRAIN: wait until the final window is accepted, then go to NEXT.
- NEXT (1 cycle):
  - Increment `depth`; at IFM_DEPTH wrap it to 0 and increment `filter`.
  - Clear `rd_pix` and `push_pix`.
  - If `filter` wrapped past NUMBER_OF_FILTERS-1, go to DONE; otherwise go to LOAD.
  - The FIFO is not flushed: the first valid window of the next channel needs FIFO_SIZE new pixels, which evicts the old data.
- DONE: pulse `done`, then go to IDLE.
- `wm_addr`, `first_depth` and `last_depth` are combinational from the `filter`/`depth` registers and stay stable for the whole channel.
- Reset in any state forces IDLE and clears every counter and `rd_pending` in the same cycle.

## Timing
- Reset values: all outputs 0, including `ifm_rd_addr`, `ofm_wr_addr` and `wm_addr`.
- `start` seen at edge t → `busy`=1 and first `ifm_rd_en` at cycle t+1.
- RAM read latency is 1: `fifo_enable` for a pixel asserts the cycle after its `ifm_rd_en` (with no stall).
- `window_valid` asserts the cycle after the qualifying `fifo_enable`.
- Stall: while `window_valid && !window_ready`:
  - `ifm_rd_en`=0, `fifo_enable`=0, counters hold.
  - `window_valid` and `ofm_wr_addr` hold.
  - The in-flight RAM word is pushed on resume.
- Accept and new window in the same cycle: the new `ofm_wr_addr` loads and `window_valid` stays 1.
- Throughput: 1 pixel/cycle with `window_ready` tied high.
- Per channel with no stall: IFM_SIZE² + 3 cycles from LOAD entry to LOAD re-entry.
- `start` outside IDLE is ignored.

## Configuration
- `CONV_WIN_CTRL_STALL_CNT_EN` defined:
  - Adds output `stall_cycles` (32 bits), counting cycles with `window_valid && !window_ready`.
  - Cleared on `reset` and on accepted `start`; saturates at 2³²-1.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- A shared package `conv_pkg` holds the state enum and the address-width helper functions used by the sibling layer controllers.
- One sub-module, `conv_window_pos`: row/column counters, the valid-position compare and `ofm_wr_addr` generation, advancing on `fifo_enable`.

## Test plan
Configuration for all scenarios: IFM_SIZE=8, K=3, IFM_DEPTH=2, NUMBER_OF_FILTERS=2.
- Reset then idle → all outputs 0 for 20 cycles; `start` mid-LOAD is ignored.
- `start`, `window_ready`=1 → per channel exactly 36 `window_valid` cycles; `ofm_wr_addr` runs 0..35 in order; the first valid window follows the push of pixel 18.
- Full run → `wm_addr` sequence 0,1,2,3; `first_depth`/`last_depth` correct per channel; `done` pulses once, 4×(64+3)+1 cycles after LOAD entry.
- `window_ready` low 5 cycles at window 10 → `ifm_rd_en`/`fifo_enable` low, `ofm_wr_addr`=10 held; no pixel lost (FIFO tap check against a model); with the macro defined, `stall_cycles`=5.
- Random `window_ready` (50%) → window/address sequence identical to the no-stall run.
- `reset` asserted during DRAIN of channel 1 → next cycle IDLE with all outputs 0; a new `start` restarts at `wm_addr`=0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution layer controllers: FSM state encoding and
// counter-width helpers.
package conv_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StLoad  = 3'd1;
  localparam state_t StDrain = 3'd2;
  localparam state_t StNext  = 3'd3;
  localparam state_t StDone  = 3'd4;

  // Bits needed to hold any value in 0..max_val (never less than one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/conv_window_pos.sv
// Row/column tracker for pixels pushed into the window FIFO; raises window_valid and the
// OFM address whenever the newest pixel completes a non-wrapping KxK window.
module conv_window_pos
  import conv_pkg::*;
#(
  parameter int unsigned IFM_SIZE              = 32,
  parameter int unsigned KERNAL_SIZE           = 6,
  parameter int unsigned IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
  parameter int unsigned ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             push,
  input  logic                             window_ready,
  output logic                             window_valid,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_wr_addr
);

  localparam int unsigned PosW = cnt_width(IFM_SIZE - 1);
  localparam logic [PosW-1:0] PosLast = PosW'(IFM_SIZE - 1);
  localparam logic [PosW-1:0] PosFirstWin = PosW'(KERNAL_SIZE - 1);
  localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] OfmLast =
      ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);

  logic [PosW-1:0]                  row_q, row_d, col_q, col_d;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_cnt_q, ofm_cnt_d, addr_q, addr_d;
  logic                             valid_q, valid_d;
  logic                             hit;

  assign hit = push && (row_q >= PosFirstWin) && (col_q >= PosFirstWin);

  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    ofm_cnt_d = ofm_cnt_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    if (push) begin
      if (col_q == PosLast) begin
        col_d = '0;
        row_d = (row_q == PosLast) ? '0 : row_q + PosW'(1);
      end else begin
        col_d = col_q + PosW'(1);
      end
    end
    // Windows appear in raster order, so a running count equals (r-K+1)*N + (c-K+1).
    if (hit) begin
      ofm_cnt_d = (ofm_cnt_q == OfmLast) ? '0 : ofm_cnt_q + ADDRESS_SIZE_NEXT_IFM'(1);
      valid_d   = 1'b1;
      addr_d    = ofm_cnt_q;
    end else if (window_ready) begin
      valid_d = 1'b0;
    end
    if (clear) begin
      row_d     = '0;
      col_d     = '0;
      ofm_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q     <= '0;
      col_q     <= '0;
      ofm_cnt_q <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      ofm_cnt_q <= ofm_cnt_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
    end
  end

  assign window_valid = valid_q;
  assign ofm_wr_addr  = addr_q;

endmodule

// File: rtl/conv_window_ctrl.sv
// Sliding-window sequencer: streams each IFM channel through the window FIFO for every
// filter/channel pair. Optional stall counter enabled by CONV_WIN_CTRL_STALL_CNT_EN.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned IFM_SIZE              = 32,
  parameter int unsigned IFM_DEPTH             = 3,
  parameter int unsigned KERNAL_SIZE           = 6,
  parameter int unsigned NUMBER_OF_FILTERS     = 6,
  parameter int unsigned IFM_SIZE_NEXT         = IFM_SIZE - KERNAL_SIZE + 1,
  parameter int unsigned ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE * IFM_DEPTH),
  parameter int unsigned ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
  parameter int unsigned ADDRESS_SIZE_WM       = $clog2(IFM_DEPTH * NUMBER_OF_FILTERS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             ifm_rd_en,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_rd_addr,
  output logic                             fifo_enable,
  output logic                             window_valid,
  input  logic                             window_ready,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_wr_addr,
  output logic [ADDRESS_SIZE_WM-1:0]       wm_addr,
  output logic                             first_depth,
  output logic                             last_depth,
  output logic                             busy,
  output logic                             done
`ifdef CONV_WIN_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]                      stall_cycles
`endif
);

  localparam int unsigned PixCount = IFM_SIZE * IFM_SIZE;
  localparam int unsigned PixW     = cnt_width(PixCount);
  localparam int unsigned DepW     = cnt_width(IFM_DEPTH - 1);
  localparam int unsigned FilW     = cnt_width(NUMBER_OF_FILTERS - 1);
  localparam logic [PixW-1:0] PixLast = PixW'(PixCount - 1);
  localparam logic [DepW-1:0] DepLast = DepW'(IFM_DEPTH - 1);
  localparam logic [FilW-1:0] FilLast = FilW'(NUMBER_OF_FILTERS - 1);

  state_t          state_q, state_d;
  logic [PixW-1:0] rd_pix_q, rd_pix_d, push_pix_q, push_pix_d;
  logic [DepW-1:0] depth_q, depth_d;
  logic [FilW-1:0] filter_q, filter_d;
  logic            rd_pending_q, rd_pending_d;
  logic            advance, start_acc, pos_clear, chan_active;

  assign advance     = !(window_valid && !window_ready);
  assign start_acc   = (state_q == StIdle) && start;
  assign pos_clear   = start_acc || (state_q == StNext);
  assign chan_active = (state_q == StLoad) || (state_q == StDrain);

  assign ifm_rd_en   = (state_q == StLoad) && advance && (32'(rd_pix_q) < PixCount);
  // The RAM word stays on its output until pushed, so a stall only delays the push.
  assign fifo_enable = rd_pending_q && advance;

  always_comb begin
    state_d      = state_q;
    rd_pix_d     = rd_pix_q;
    push_pix_d   = push_pix_q;
    depth_d      = depth_q;
    filter_d     = filter_q;
    rd_pending_d = rd_pending_q;
    if (ifm_rd_en) begin
      rd_pix_d     = rd_pix_q + PixW'(1);
      rd_pending_d = 1'b1;
    end else if (fifo_enable) begin
      rd_pending_d = 1'b0;
    end
    if (fifo_enable) begin
      push_pix_d = push_pix_q + PixW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rd_pix_d   = '0;
          push_pix_d = '0;
          depth_d    = '0;
          filter_d   = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (fifo_enable && (push_pix_q == PixLast)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (advance) begin
          state_d = StNext;
        end
      end
      StNext: begin
        rd_pix_d   = '0;
        push_pix_d = '0;
        state_d    = StLoad;
        if (depth_q == DepLast) begin
          depth_d = '0;
          if (filter_q == FilLast) begin
            filter_d = '0;
            state_d  = StDone;
          end else begin
            filter_d = filter_q + FilW'(1);
          end
        end else begin
          depth_d = depth_q + DepW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rd_pix_q     <= '0;
      push_pix_q   <= '0;
      depth_q      <= '0;
      filter_q     <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_pix_q     <= rd_pix_d;
      push_pix_q   <= push_pix_d;
      depth_q      <= depth_d;
      filter_q     <= filter_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  conv_window_pos #(
    .IFM_SIZE              (IFM_SIZE),
    .KERNAL_SIZE           (KERNAL_SIZE),
    .IFM_SIZE_NEXT         (IFM_SIZE_NEXT),
    .ADDRESS_SIZE_NEXT_IFM (ADDRESS_SIZE_NEXT_IFM)
  ) u_pos (
    .clk          (clk),
    .reset        (reset),
    .clear        (pos_clear),
    .push         (fifo_enable),
    .window_ready (window_ready),
    .window_valid (window_valid),
    .ofm_wr_addr  (ofm_wr_addr)
  );

  assign ifm_rd_addr = ADDRESS_SIZE_IFM'(32'(depth_q) * PixCount + 32'(rd_pix_q));
  assign wm_addr     = ADDRESS_SIZE_WM'(32'(filter_q) * IFM_DEPTH + 32'(depth_q));
  assign first_depth = chan_active && (depth_q == '0);
  assign last_depth  = chan_active && (depth_q == DepLast);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);

`ifdef CONV_WIN_CTRL_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      stall_q <= '0;
    end else if (window_valid && !window_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: cycle-vector table for the no-stall run plus a window
// scoreboard with a RAM/FIFO tap model, checked under tied, stalled and random ready.
module tb_conv_window_ctrl;

  localparam int S = 8;
  localparam int K = 3;
  localparam int D = 2;
  localparam int F = 2;
  localparam int N = S - K + 1;
  localparam int FifoSize = (K - 1) * S + K;
  localparam int NumVec = 19;

  typedef struct {
    int         c;
    logic [6:0] flags;   // {busy, ifm_rd_en, fifo_enable, window_valid, done, first, last}
    int         rd_addr; // -1: don't care
    int         ofm;     // -1: don't care
    int         wm;
  } vec_t;

  typedef struct {
    int ofm;
    int wm;
    bit first;
    bit last;
    int depth;
  } win_t;

  logic       clk, reset, start, window_ready;
  logic       ifm_rd_en, fifo_enable, window_valid, first_depth, last_depth, busy, done;
  logic [6:0] ifm_rd_addr;
  logic [5:0] ofm_wr_addr;
  logic [1:0] wm_addr;
`ifdef CONV_WIN_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  conv_window_ctrl #(
    .IFM_SIZE          (S),
    .IFM_DEPTH         (D),
    .KERNAL_SIZE       (K),
    .NUMBER_OF_FILTERS (F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ifm_rd_en    (ifm_rd_en),
    .ifm_rd_addr  (ifm_rd_addr),
    .fifo_enable  (fifo_enable),
    .window_valid (window_valid),
    .window_ready (window_ready),
    .ofm_wr_addr  (ofm_wr_addr),
    .wm_addr      (wm_addr),
    .first_depth  (first_depth),
    .last_depth   (last_depth),
    .busy         (busy),
    .done         (done)
`ifdef CONV_WIN_CTRL_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   ready_mode = 0;
  bit   stall_arm = 0;
  int   stall_seen = 0;
  int   done_cnt = 0;
  int   done_c = -1;
  bit   mon_en = 0;
  win_t exp_q[$];
  win_t w;
  int   fifo_m[FifoSize];
  int   ram_q = 0;
  vec_t vecs[NumVec];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pix_val(input int addr);
    return addr * 5 + 11;
  endfunction

  function automatic longint all_outs();
    return longint'({ifm_rd_en, ifm_rd_addr, fifo_enable, window_valid, ofm_wr_addr,
                     wm_addr, first_depth, last_depth, busy, done});
  endfunction

  task automatic push_expected();
    for (int f = 0; f < F; f++)
      for (int d = 0; d < D; d++)
        for (int a = 0; a < N * N; a++)
          exp_q.push_back('{a, f * D + d, d == 0, d == D - 1, d});
  endtask

  // window_ready driver: 0 tied high, 1 five-cycle stall at window 10, 2 random
  initial begin
    int stall_left;
    window_ready = 1'b1;
    stall_left = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        window_ready = 1'b1;
      end else if (ready_mode == 1) begin
        if (stall_left > 0) begin
          window_ready = 1'b0;
          stall_left--;
        end else if (stall_arm && window_valid && ofm_wr_addr == 6'd10) begin
          window_ready = 1'b0;
          stall_left = 4;
          stall_arm = 0;
        end else begin
          window_ready = 1'b1;
        end
      end else begin
        window_ready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  // Scoreboard: RAM and window-FIFO model, accepted windows popped and compared.
  initial begin
    longint act_sum, exp_sum;
    int orow, ocol, idx;
    for (int i = 0; i < FifoSize; i++) fifo_m[i] = 0;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (done) begin
          done_cnt++;
          done_c = cyc - start_cyc;
        end
        if (ready_mode == 1 && window_valid && !window_ready) begin
          stall_seen++;
          check("stall_hold", longint'({ifm_rd_en, fifo_enable, ofm_wr_addr}),
                longint'({1'b0, 1'b0, 6'd10}));
        end
        if (window_valid && window_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_window: got ofm %0d expected no window", ofm_wr_addr);
          end else begin
            w = exp_q.pop_front();
            check("window_fields", longint'({ofm_wr_addr, wm_addr, first_depth, last_depth}),
                  (longint'(w.ofm) << 4) | (longint'(w.wm) << 2) |
                  (longint'(w.first) << 1) | longint'(w.last));
            orow = w.ofm / N;
            ocol = w.ofm % N;
            act_sum = 0;
            exp_sum = 0;
            for (int i = 0; i < K; i++)
              for (int j = 0; j < K; j++) begin
                idx = (K - 1 - i) * S + (K - 1 - j);
                act_sum += longint'(fifo_m[idx]) * (i * K + j + 1);
                exp_sum += longint'(pix_val(w.depth * S * S + (orow + i) * S + ocol + j)) *
                           (i * K + j + 1);
              end
            check("window_taps", act_sum, exp_sum);
          end
        end
        if (fifo_enable) begin
          for (int i = FifoSize - 1; i > 0; i--) fifo_m[i] = fifo_m[i - 1];
          fifo_m[0] = ram_q;
        end
        if (ifm_rd_en) ram_q = pix_val(int'(ifm_rd_addr));
      end
    end
  end

  task automatic check_vec(input vec_t v);
    check($sformatf("c%0d_flags", v.c),
          longint'({busy, ifm_rd_en, fifo_enable, window_valid, done, first_depth, last_depth}),
          longint'(v.flags));
    check($sformatf("c%0d_wm_addr", v.c), longint'(wm_addr), v.wm);
    if (v.rd_addr >= 0) check($sformatf("c%0d_rd_addr", v.c), longint'(ifm_rd_addr), v.rd_addr);
    if (v.ofm >= 0) check($sformatf("c%0d_ofm_addr", v.c), longint'(ofm_wr_addr), v.ofm);
  endtask

  // c counts edges since the one that sampled start; c=0 is the first LOAD cycle.
  task automatic do_run(input int mode, input bit use_tbl, input int exp_done);
    int c;
    int ti;
    ready_mode = mode;
    stall_arm = (mode == 1);
    stall_seen = 0;
    done_cnt = 0;
    done_c = -1;
    push_expected();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc = cyc;
    ti = 0;
    forever begin
      @(negedge clk);
      c = cyc - start_cyc;
      if (c == 0)
        check("start_first_cycle", longint'({busy, ifm_rd_en, ifm_rd_addr, wm_addr}),
              longint'({1'b1, 1'b1, 7'd0, 2'd0}));
      if (use_tbl)
        while (ti < NumVec && vecs[ti].c == c) begin
          check_vec(vecs[ti]);
          ti++;
        end
      if (done_c >= 0 && c >= done_c + 1) break;
      if (c >= 3000) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done after %0d cycles expected done", c);
        break;
      end
      @(posedge clk);
      #1;
      start = use_tbl && (c == 29);  // ignored: the DUT is mid-LOAD
    end
    start = 1'b0;
    check("done_pulses", done_cnt, 1);
    check("windows_left", exp_q.size(), 0);
    exp_q.delete();
    // 268 edges after LOAD entry = 4*(64+3)+1 cycles counting the LOAD entry cycle
    if (exp_done >= 0) check("done_cycle", done_c, exp_done);
    if (mode == 1) begin
      check("stall_cycles_seen", stall_seen, 5);
`ifdef CONV_WIN_CTRL_STALL_CNT_EN
      check("stall_cycles_port", longint'(stall_cycles), 5);
`endif
    end
  endtask

  task automatic reset_in_drain();
    int c;
    ready_mode = 0;
    done_cnt = 0;
    done_c = -1;
    push_expected();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc = cyc;
    c = 0;
    while (c < 132) begin
      @(posedge clk);
      #1;
      c = cyc - start_cyc;
    end
    mon_en = 0;
    @(negedge clk);
    check("drain_ch1_state", longint'({window_valid, ifm_rd_en, fifo_enable, busy, wm_addr}),
          longint'({1'b1, 1'b0, 1'b0, 1'b1, 2'd1}));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("reset_in_drain_outputs", all_outs(), 0);
    mon_en = 1;
  endtask

  initial begin
    vecs[0]  = '{0,   7'b1100010,  0, -1, 0};
    vecs[1]  = '{1,   7'b1110010,  1, -1, 0};
    vecs[2]  = '{19,  7'b1110010, 19, -1, 0};
    vecs[3]  = '{20,  7'b1111010, 20,  0, 0};
    vecs[4]  = '{24,  7'b1111010, 24,  4, 0};
    vecs[5]  = '{25,  7'b1111010, 25,  5, 0};
    vecs[6]  = '{26,  7'b1110010, 26, -1, 0};
    vecs[7]  = '{28,  7'b1111010, 28,  6, 0};
    vecs[8]  = '{31,  7'b1111010, 31,  9, 0};
    vecs[9]  = '{32,  7'b1111010, 32, 10, 0};
    vecs[10] = '{64,  7'b1011010, -1, 34, 0};
    vecs[11] = '{65,  7'b1001010, -1, 35, 0};
    vecs[12] = '{66,  7'b1000000, -1, -1, 0};
    vecs[13] = '{67,  7'b1100001, 64, -1, 1};
    vecs[14] = '{134, 7'b1100010,  0, -1, 2};
    vecs[15] = '{201, 7'b1100001, 64, -1, 3};
    vecs[16] = '{267, 7'b1000000, -1, -1, 3};
    vecs[17] = '{268, 7'b1000100, -1, -1, 0};
    vecs[18] = '{269, 7'b0000000, -1, -1, 0};

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_outputs_%0d", i), all_outs(), 0);
    end
    mon_en = 1;

    do_run(0, 1, 268);
    do_run(1, 0, 273);
    do_run(2, 0, -1);
    reset_in_drain();
    do_run(0, 0, 268);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
